// File: rtl/acacia_requester.sv
// Client-side requester for the 3-way acacia arbiter: three independent job channels that
// hold their request line until the job's granted cycles are used, plus mutex/starvation monitors.
module acacia_requester #(
    parameter int LEN_W    = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         job_valid,
    input  logic [3*LEN_W-1:0] job_len,
    output logic [2:0]         job_ready,
    output logic               r0,
    output logic               r1,
    output logic               r2,
    input  logic               a0,
    input  logic               a1,
    input  logic               a2,
    output logic [2:0]         done,
    output logic [2:0]         starve,
    output logic               err_mutex
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} state_t;

    logic [2:0] grant;
    logic [2:0] req;

    assign grant = {a2, a1, a0};
    assign r0    = req[0];
    assign r1    = req[1];
    assign r2    = req[2];

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        state_t            state, state_nx;
        logic [LEN_W-1:0]  len_q, len_nx, used_q, used_nx;
        logic [WAIT_W-1:0] wait_q, wait_nx;
        logic [LEN_W-1:0]  len_in;
        logic              starve_set;
        logic              req_q, done_q, starve_q;

        assign len_in = job_len[ch*LEN_W +: LEN_W];

        always_comb begin
            state_nx   = state;
            len_nx     = len_q;
            used_nx    = used_q;
            wait_nx    = wait_q;
            starve_set = 1'b0;
            case (state)
                IDLE: if (job_valid[ch]) begin
                    // A zero-length job still needs one granted cycle to complete.
                    len_nx   = (len_in == '0) ? LEN_W'(1) : len_in;
                    used_nx  = '0;
                    wait_nx  = '0;
                    state_nx = REQ;
                end
                REQ: if (grant[ch]) begin
                    used_nx  = LEN_W'(1);
                    state_nx = (len_q == LEN_W'(1)) ? REL : HOLD;
                end else if (wait_q != WAIT_MAX) begin
                    wait_nx = wait_q + WAIT_W'(1);
                    if (wait_nx == WAIT_MAX) starve_set = 1'b1;
                end
                HOLD: if (grant[ch]) begin
                    used_nx = used_q + LEN_W'(1);
                    if (used_nx == len_q) state_nx = REL;
                end
                REL: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                len_q    <= '0;
                used_q   <= '0;
                wait_q   <= '0;
                req_q    <= 1'b0;
                done_q   <= 1'b0;
                starve_q <= 1'b0;
            end else begin
                state  <= state_nx;
                len_q  <= len_nx;
                used_q <= used_nx;
                wait_q <= wait_nx;
                // Outputs registered from the next state so they align with the state register.
                req_q  <= (state_nx == REQ) || (state_nx == HOLD);
                done_q <= (state_nx == REL);
                if (starve_set) starve_q <= 1'b1;
            end
        end

        assign req[ch]       = req_q;
        assign done[ch]      = done_q;
        assign starve[ch]    = starve_q;
        assign job_ready[ch] = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mutex <= 1'b0;
        end else if ((a0 & a1) | (a0 & a2) | (a1 & a2)) begin
            err_mutex <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acacia_requester.sv
// Self-checking bench for acacia_requester: directed scenarios plus randomized traffic
// compared against a job-level behavioural model (grants counted per job).
module tb_acacia_requester;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  job_valid;
    logic [11:0] job_len;
    logic [2:0]  g;
    logic [2:0]  job_ready, done, starve;
    logic        r0, r1, r2, err_mutex;
    logic [12:0] dv;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a job is "active" until it has collected need grants, then one finishing cycle.
    bit m_act[3], m_fin[3], m_starve[3], m_mutex;
    int m_need[3], m_got[3], m_wait[3];

    acacia_requester #(.LEN_W(4), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_len(job_len),
        .job_ready(job_ready), .r0(r0), .r1(r1), .r2(r2),
        .a0(g[0]), .a1(g[1]), .a2(g[2]),
        .done(done), .starve(starve), .err_mutex(err_mutex)
    );

    always #5 clk = ~clk;

    assign dv = {job_ready, r2, r1, r0, done, starve, err_mutex};

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_fin[i] = 0; m_starve[i] = 0;
            m_need[i] = 0; m_got[i] = 0; m_wait[i] = 0;
        end
        m_mutex = 0;
    endfunction

    function automatic void model_edge(input logic [2:0] v, input logic [11:0] l, input logic [2:0] gr);
        if ($countones(gr) >= 2) m_mutex = 1;
        for (int i = 0; i < 3; i++) begin
            if (m_fin[i]) begin
                m_fin[i] = 0;
            end else if (!m_act[i]) begin
                if (v[i]) begin
                    m_act[i]  = 1;
                    m_need[i] = int'(l[i*4 +: 4]);
                    if (m_need[i] == 0) m_need[i] = 1;
                    m_got[i]  = 0;
                    m_wait[i] = 0;
                end
            end else if (gr[i]) begin
                m_got[i]++;
                if (m_got[i] == m_need[i]) begin
                    m_act[i] = 0;
                    m_fin[i] = 1;
                end
            end else if (m_got[i] == 0) begin
                if (m_wait[i] < MAXW) m_wait[i]++;
                if (m_wait[i] == MAXW) m_starve[i] = 1;
            end
        end
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [2:0] rdy, rq, dn, st;
        for (int i = 0; i < 3; i++) begin
            rdy[i] = !m_act[i] && !m_fin[i];
            rq[i]  = m_act[i];
            dn[i]  = m_fin[i];
            st[i]  = m_starve[i];
        end
        return {rdy, rq, dn, st, m_mutex};
    endfunction

    task automatic step(input logic [2:0] v, input logic [11:0] l, input logic [2:0] gr);
        job_valid = v; job_len = l; g = gr;
        @(posedge clk);
        if (rst_n) model_edge(v, l, gr);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; job_valid = '0; job_len = '0; g = '0;
        #1 rst_n = 1'b0;
        #6;
        n_tests++;
        if (dv !== 13'b111_000_000_000_0) begin
            n_fail++; $display("FAIL reset_outputs act=%b req=%b", dv, 13'b111_000_000_000_0);
        end
        #3 rst_n = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (job_ready !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready act=%b req=111", job_ready);
        end
    endtask

    task automatic test_len3();
        logic exp_r[3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        step(3'b001, 12'h003, 3'b000);
        n_tests++;
        if (r0 !== 1'b1 || job_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL len3_accept r0=%b rdy=%b req r0=1 rdy=0", r0, job_ready[0]);
        end
        for (int k = 0; k < 3; k++) begin
            step(3'b000, 12'h000, 3'b001);
            n_tests++;
            if (r0 !== exp_r[k] || done[0] !== !exp_r[k]) begin
                n_fail++; $display("FAIL len3_grant%0d r0=%b done0=%b req r0=%b done0=%b", k, r0, done[0], exp_r[k], !exp_r[k]);
            end
        end
        step(3'b000, 12'h000, 3'b000);
        n_tests++;
        if (r0 !== 1'b0 || done[0] !== 1'b0 || job_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL len3_idle r0=%b done0=%b rdy0=%b req 0,0,1", r0, done[0], job_ready[0]);
        end
    endtask

    task automatic test_len0();
        do_reset();
        step(3'b100, 12'h000, 3'b000);
        n_tests++;
        if (r2 !== 1'b1) begin
            n_fail++; $display("FAIL len0_req r2=%b req 1", r2);
        end
        step(3'b000, 12'h000, 3'b100);
        n_tests++;
        if (r2 !== 1'b0 || done !== 3'b100) begin
            n_fail++; $display("FAIL len0_done r2=%b done=%b req r2=0 done=100", r2, done);
        end
        step(3'b000, 12'h000, 3'b000);
        n_tests++;
        if (done !== 3'b000 || job_ready !== 3'b111) begin
            n_fail++; $display("FAIL len0_idle done=%b rdy=%b req 000,111", done, job_ready);
        end
    endtask

    task automatic test_preempt();
        int pat[6] = '{1, 1, 0, 0, 1, 1};
        do_reset();
        step(3'b010, 12'h040, 3'b000);
        for (int k = 0; k < 6; k++) begin
            step(3'b000, 12'h000, pat[k] != 0 ? 3'b010 : 3'b000);
            n_tests++;
            if (k < 5 && (r1 !== 1'b1 || done[1] !== 1'b0)) begin
                n_fail++; $display("FAIL preempt_hold%0d r1=%b done1=%b req 1,0", k, r1, done[1]);
            end else if (k == 5 && (r1 !== 1'b0 || done[1] !== 1'b1)) begin
                n_fail++; $display("FAIL preempt_done r1=%b done1=%b req 0,1", r1, done[1]);
            end
        end
        n_tests++;
        if (starve[1] !== 1'b0) begin
            n_fail++; $display("FAIL preempt_starve act=%b req 0", starve[1]);
        end
    endtask

    task automatic test_starve();
        do_reset();
        step(3'b001, 12'h002, 3'b000);
        for (int k = 1; k <= 16; k++) begin
            step(3'b000, 12'h000, 3'b000);
            if (k >= 15) begin
                n_tests++;
                if (starve[0] !== (k == 16)) begin
                    n_fail++; $display("FAIL starve_wait%0d act=%b req=%b", k, starve[0], (k == 16));
                end
            end
        end
        step(3'b000, 12'h000, 3'b001);
        step(3'b000, 12'h000, 3'b001);
        n_tests++;
        if (done[0] !== 1'b1 || starve[0] !== 1'b1) begin
            n_fail++; $display("FAIL starve_done done0=%b starve0=%b req 1,1", done[0], starve[0]);
        end
        step(3'b000, 12'h000, 3'b000);
        n_tests++;
        if (starve !== 3'b001) begin
            n_fail++; $display("FAIL starve_sticky act=%b req=001", starve);
        end
    endtask

    task automatic test_mutex();
        do_reset();
        step(3'b010, 12'h002, 3'b000);
        step(3'b000, 12'h000, 3'b101);
        n_tests++;
        if (err_mutex !== 1'b1 || dv !== exp_vec()) begin
            n_fail++; $display("FAIL mutex_set act=%b req=%b", dv, exp_vec());
        end
        step(3'b000, 12'h000, 3'b000);
        n_tests++;
        if (err_mutex !== 1'b1 || r0 !== 1'b0 || r2 !== 1'b0 || r1 !== 1'b1 || job_ready !== 3'b101) begin
            n_fail++; $display("FAIL mutex_sticky act=%b req err=1 r=010 rdy=101", dv);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        step(3'b010, 12'h050, 3'b000);
        step(3'b000, 12'h000, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (r1 !== 1'b0 || done !== 3'b000 || job_ready !== 3'b111) begin
            n_fail++; $display("FAIL midreset r1=%b done=%b rdy=%b req 0,000,111", r1, done, job_ready);
        end
        #1 rst_n = 1'b1;
        model_reset();
        step(3'b000, 12'h000, 3'b010);
        n_tests++;
        if (r1 !== 1'b0 || done !== 3'b000) begin
            n_fail++; $display("FAIL midreset_discard r1=%b done=%b req 0,000", r1, done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(3'b100, 12'h100, 3'b100);
            n_tests++;
            if (r2 !== (k % 3 == 0) || done[2] !== (k % 3 == 1) || dv !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_%0d r2=%b done2=%b req %b,%b", k, r2, done[2], (k % 3 == 0), (k % 3 == 1));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] v, gr;
        int sel;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            v   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 19);
            if (sel < 12)      gr = 3'(1 << (sel % 3));
            else if (sel < 19) gr = 3'b000;
            else               gr = 3'($urandom_range(0, 7));
            step(v, 12'($urandom), gr);
            n_tests++;
            if (dv !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d act=%b req=%b", k, dv, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_len3();
        test_len0();
        test_preempt();
        test_starve();
        test_mutex();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
